// File: rtl/led_bar_serializer_pkg.sv
// Shared types and sizing helpers for the LED bar serializer.
package led_bar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Default geometry of the board LED bar.
    localparam int LED_WIDTH   = 10;
    localparam int LED_CLK_DIV = 4;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Bit counter covers 0..WIDTH, divider counter covers 0..CLK_DIV-1.
    localparam int BIT_CNT_W = $clog2(LED_WIDTH + 1);
    localparam int DIV_CNT_W = cnt_w(LED_CLK_DIV);

endpackage

// File: rtl/led_bar_serializer_if.sv
// Bus between the LED PIO side (master) and the serializer (slave).
interface led_bar_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] wr_val;
    logic             enable;
    logic             sclk;
    logic             sdata;
    logic             slatch;
    logic             busy;
    logic [15:0]      frame_count;

    modport master (
        output wr_val, enable,
        input  sclk, sdata, slatch, busy, frame_count
    );

    modport slave (
        input  wr_val, enable,
        output sclk, sdata, slatch, busy, frame_count
    );
endinterface

// File: rtl/led_bar_serializer_sclk_tick.sv
// Half-period timebase for SCLK: free-running 0..CLK_DIV-1 counter,
// restarted at frame start so the first bit gets a full low phase.
module led_sclk_tick
    import led_bar_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr_i,
    output logic half_tick_o
);
    localparam int              CW   = cnt_w(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count half-period cycles; wrap at LAST or restart on frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr_i || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign half_tick_o = (cnt_q == LAST);
endmodule

// File: rtl/led_bar_serializer.sv
// Ships the LED PIO value to a SIPO LED driver over SCLK/SDATA/SLATCH.
// Frames go out only on change (plus one forced frame after reset);
// updates that arrive mid-frame coalesce into the next frame.
module led_bar_serializer
    import led_bar_pkg::*;
#(
    parameter int WIDTH        = LED_WIDTH,
    parameter int CLK_DIV      = LED_CLK_DIV,
    parameter int LATCH_CYCLES = 2,
    parameter int MSB_FIRST    = 1
) (
    input  logic clk,
    input  logic reset_n,
    led_bar_if.slave led
);
    localparam int                BCW      = $clog2(WIDTH + 1);
    localparam int                LCW      = cnt_w(LATCH_CYCLES);
    localparam logic [BCW-1:0]    LAST_BIT = BCW'(WIDTH - 1);
    localparam logic [LCW-1:0]    LAST_LAT = LCW'(LATCH_CYCLES - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   shift_q;
    logic [WIDTH-1:0]   last_q;
    logic               init_pend_q;
    logic [BCW-1:0]     bit_cnt_q;
    logic [LCW-1:0]     latch_cnt_q;
    logic               sclk_q;
    logic               sdata_q;
    logic               slatch_q;
    logic               busy_q;
    logic [15:0]        frame_cnt_q;

    logic               start;
    logic               half_tick;
    logic [WIDTH-1:0]   shift_nxt;

    // Bit presented first on the wire for a given word.
    function automatic logic first_bit(input logic [WIDTH-1:0] v);
        return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
    endfunction

    assign start     = (state_q == IDLE) && led.enable &&
                       (init_pend_q || (led.wr_val != last_q));
    assign shift_nxt = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);

    led_sclk_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr_i       (start),
        .half_tick_o (half_tick)
    );

    // Frame sequencer: capture in IDLE, clock bits out in SHIFT, strobe in LATCH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            last_q      <= '0;
            init_pend_q <= 1'b1;
            bit_cnt_q   <= '0;
            latch_cnt_q <= '0;
            sclk_q      <= 1'b0;
            sdata_q     <= 1'b0;
            slatch_q    <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q     <= led.wr_val;
                        last_q      <= led.wr_val;
                        init_pend_q <= 1'b0;
                        busy_q      <= 1'b1;
                        sclk_q      <= 1'b0;
                        sdata_q     <= first_bit(led.wr_val);
                        bit_cnt_q   <= '0;
                        state_q     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (half_tick) begin
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            // Falling toggle ends the current bit.
                            sclk_q <= 1'b0;
                            if (bit_cnt_q == LAST_BIT) begin
                                sdata_q     <= 1'b0;
                                slatch_q    <= 1'b1;
                                latch_cnt_q <= '0;
                                state_q     <= LATCH;
                            end else begin
                                shift_q   <= shift_nxt;
                                sdata_q   <= first_bit(shift_nxt);
                                bit_cnt_q <= bit_cnt_q + BCW'(1);
                            end
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt_q == LAST_LAT) begin
                        slatch_q    <= 1'b0;
                        busy_q      <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= IDLE;
                    end else begin
                        latch_cnt_q <= latch_cnt_q + LCW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign led.sclk        = sclk_q;
    assign led.sdata       = sdata_q;
    assign led.slatch      = slatch_q;
    assign led.busy        = busy_q;
    assign led.frame_count = frame_cnt_q;
endmodule

// File: tb/tb_led_bar_serializer.sv
// Bench for led_bar_serializer: three configurations share stimulus and are
// checked every cycle against a timestamp-level reference model.
module tb_led_bar_serializer;
    import led_bar_pkg::*;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic [9:0] wr      = '0;
    logic       en      = 1'b0;

    always #5 clk = ~clk;

    led_bar_if #(.WIDTH(10)) ifa ();
    led_bar_if #(.WIDTH(1))  ifb ();
    led_bar_if #(.WIDTH(10)) ifc ();

    assign ifa.wr_val = wr;
    assign ifa.enable = en;
    assign ifb.wr_val = wr[0:0];
    assign ifb.enable = en;
    assign ifc.wr_val = wr;
    assign ifc.enable = en;

    led_bar_serializer #(.WIDTH(10), .CLK_DIV(4), .LATCH_CYCLES(2), .MSB_FIRST(1))
        u_a (.clk(clk), .reset_n(reset_n), .led(ifa));
    led_bar_serializer #(.WIDTH(1), .CLK_DIV(1), .LATCH_CYCLES(2), .MSB_FIRST(1))
        u_b (.clk(clk), .reset_n(reset_n), .led(ifb));
    led_bar_serializer #(.WIDTH(10), .CLK_DIV(2), .LATCH_CYCLES(3), .MSB_FIRST(0))
        u_c (.clk(clk), .reset_n(reset_n), .led(ifc));

    logic        o_sclk [3];
    logic        o_sdata [3];
    logic        o_slatch [3];
    logic        o_busy [3];
    logic [15:0] o_cnt [3];

    assign o_sclk[0] = ifa.sclk;   assign o_sclk[1] = ifb.sclk;   assign o_sclk[2] = ifc.sclk;
    assign o_sdata[0] = ifa.sdata; assign o_sdata[1] = ifb.sdata; assign o_sdata[2] = ifc.sdata;
    assign o_slatch[0] = ifa.slatch; assign o_slatch[1] = ifb.slatch; assign o_slatch[2] = ifc.slatch;
    assign o_busy[0] = ifa.busy;   assign o_busy[1] = ifb.busy;   assign o_busy[2] = ifc.busy;
    assign o_cnt[0] = ifa.frame_count; assign o_cnt[1] = ifb.frame_count; assign o_cnt[2] = ifc.frame_count;

    // Configuration table: width, latch cycles, bit order, busy length, value mask.
    localparam int         P_W   [3] = '{10, 1, 10};
    localparam int         P_LC  [3] = '{2, 2, 3};
    localparam int         P_MSB [3] = '{1, 1, 0};
    localparam int         P_L   [3] = '{10*2*4+2, 1*2*1+2, 10*2*2+3};
    localparam logic [9:0] P_MASK[3] = '{10'h3FF, 10'h001, 10'h3FF};

    // Reference model: per instance, remaining busy cycles and last value sent.
    bit          m_init [3];
    logic [9:0]  m_last [3];
    logic [9:0]  m_exp [3];
    int          m_left [3];
    logic [15:0] m_cnt [3];

    // Wire monitor state.
    logic        p_sclk [3];
    logic        p_slatch [3];
    logic        p_busy [3];
    logic [9:0]  col [3];
    logic [9:0]  last_frame [3];
    int          nbits [3];
    int          lat_len [3];
    int          brun [3];
    int          last_blen [3];
    int          frames_seen [3];
    int          sclk_rises [3];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_init[k]   = 1'b1;
            m_last[k]   = '0;
            m_exp[k]    = '0;
            m_left[k]   = 0;
            m_cnt[k]    = '0;
            p_sclk[k]   = 1'b0;
            p_slatch[k] = 1'b0;
            p_busy[k]   = 1'b0;
            col[k]      = '0;
            nbits[k]    = 0;
            lat_len[k]  = 0;
            brun[k]     = 0;
        end
    endtask

    // One clock: advance the model at the rising edge, check the DUTs at the falling edge.
    task automatic step();
        logic [9:0] v;
        @(posedge clk);
        if (!reset_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                v = wr & P_MASK[k];
                if (m_left[k] > 0) begin
                    m_left[k]--;
                    if (m_left[k] == 0) m_cnt[k]++;
                end else if (en && (m_init[k] || v != m_last[k])) begin
                    m_init[k] = 1'b0;
                    m_last[k] = v;
                    m_exp[k]  = v;
                    m_left[k] = P_L[k];
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy%0d", k), 32'(o_busy[k]), 32'(m_left[k] != 0));
            chk($sformatf("frame_count%0d", k), 32'(o_cnt[k]), 32'(m_cnt[k]));
            if (reset_n) begin
                if (o_sclk[k] && !p_sclk[k]) begin
                    if (P_MSB[k] != 0) col[k] = (col[k] << 1) | 10'(o_sdata[k]);
                    else               col[k] = col[k] | (10'(o_sdata[k]) << nbits[k]);
                    nbits[k]++;
                    sclk_rises[k]++;
                end
                if (o_slatch[k]) begin
                    lat_len[k]++;
                    chk($sformatf("latch_quiet%0d", k), 32'({o_sclk[k], o_sdata[k]}), 32'd0);
                end
                if (o_slatch[k] && !p_slatch[k]) begin
                    chk($sformatf("nbits%0d", k), 32'(nbits[k]), 32'(P_W[k]));
                    chk($sformatf("frame_val%0d", k), 32'(col[k] & P_MASK[k]), 32'(m_exp[k]));
                    last_frame[k] = col[k] & P_MASK[k];
                    frames_seen[k]++;
                    col[k]   = '0;
                    nbits[k] = 0;
                end
                if (!o_slatch[k] && p_slatch[k]) begin
                    chk($sformatf("latch_len%0d", k), 32'(lat_len[k]), 32'(P_LC[k]));
                    lat_len[k] = 0;
                end
                if (o_busy[k]) brun[k]++;
                else if (p_busy[k]) begin
                    last_blen[k] = brun[k];
                    brun[k]      = 0;
                end
                p_sclk[k]   = o_sclk[k];
                p_slatch[k] = o_slatch[k];
                p_busy[k]   = o_busy[k];
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && (o_busy[0] || o_busy[1] || o_busy[2])) begin
            step();
            n++;
        end
        chk("idle_wait", 32'({o_busy[0], o_busy[1], o_busy[2]}), 32'd0);
    endtask

    task automatic wait_busy_a(input int budget);
        int n;
        n = 0;
        while (n < budget && !o_busy[0]) begin
            step();
            n++;
        end
        chk("busy_wait", 32'(o_busy[0]), 32'd1);
    endtask

    int f0;
    int r0;

    initial begin
        for (int k = 0; k < 3; k++) begin
            frames_seen[k] = 0;
            sclk_rises[k]  = 0;
            last_frame[k]  = '0;
            last_blen[k]   = 0;
        end
        model_reset();

        // Reset state.
        en = 1'b1;
        wr = 10'h000;
        #3 reset_n = 1'b0;
        run(3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_pins%0d", k),
                32'({o_sclk[k], o_sdata[k], o_slatch[k], o_busy[k]}), 32'd0);
        reset_n = 1'b1;

        // Forced frame of zeros after reset, then silence.
        run(83);
        chk("t1_count", 32'(o_cnt[0]), 32'd1);
        chk("t1_frames", 32'(frames_seen[0]), 32'd1);
        chk("t1_busy_len", 32'(last_blen[0]), 32'd82);
        run(100);
        chk("t1_no_more", 32'(frames_seen[0]), 32'd1);

        // Single change: 0x2A5 MSB first.
        wr = 10'h2A5;
        wait_busy_a(5);
        wait_idle(300);
        chk("t2_value", 32'(last_frame[0]), 32'h2A5);
        chk("t2_busy_len", 32'(last_blen[0]), 32'd82);
        chk("t2_lsb_first", 32'(last_frame[2]), 32'h2A5);

        // Mid-frame updates coalesce into one further frame.
        f0 = frames_seen[0];
        wr = 10'h001;
        wait_busy_a(5);
        run(20);
        wr = 10'h002;
        run(30);
        wr = 10'h3FF;
        wait_idle(400);
        run(3);
        wait_idle(400);
        chk("t3_frames", 32'(frames_seen[0] - f0), 32'd2);
        chk("t3_value", 32'(last_frame[0]), 32'h3FF);

        // Enable gating.
        en = 1'b0;
        wr = 10'h155;
        f0 = frames_seen[0];
        r0 = sclk_rises[0];
        run(100);
        chk("t4_no_frame", 32'(frames_seen[0] - f0), 32'd0);
        chk("t4_no_sclk", 32'(sclk_rises[0] - r0), 32'd0);
        en = 1'b1;
        step();
        chk("t4_start_a", 32'(o_busy[0]), 32'd1);
        chk("t4_start_c", 32'(o_busy[2]), 32'd1);
        run(30);
        en = 1'b0;
        wait_idle(300);
        chk("t4_completed", 32'(last_frame[0]), 32'h155);

        // Reset mid-frame, then forced frame of the unchanged value.
        en = 1'b1;
        wr = 10'h0F0;
        wait_busy_a(5);
        wait_idle(300);
        wr = 10'h000;
        r0 = 0;
        while (r0 < 200 && nbits[0] < 5) begin
            step();
            r0++;
        end
        chk("t5_reach_bit5", 32'(nbits[0]), 32'd5);
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("t5_async%0d", k),
                32'({o_sclk[k], o_sdata[k], o_slatch[k], o_busy[k], o_cnt[k]}), 32'd0);
        model_reset();
        run(3);
        reset_n = 1'b1;
        f0 = frames_seen[0];
        wait_busy_a(5);
        wait_idle(300);
        chk("t5_forced", 32'(frames_seen[0] - f0), 32'd1);
        chk("t5_value", 32'(last_frame[0]), 32'h000);
        chk("t5_count", 32'(o_cnt[0]), 32'd1);

        // Counter wrap on the 1-bit, divide-by-1 instance.
        force u_b.frame_cnt_q = 16'hFFFF;
        #1;
        release u_b.frame_cnt_q;
        m_cnt[1] = 16'hFFFF;
        run(2);
        wr = 10'h001;
        run(3);
        wait_idle(300);
        chk("t6_wrap", 32'(o_cnt[1]), 32'd0);
        chk("t6_busy_len", 32'(last_blen[1]), 32'd4);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            r0 = int'($urandom_range(0, 99));
            if (r0 < 4)       wr = 10'($urandom);
            else if (r0 < 6)  wr = m_last[0];
            else if (r0 == 99) en = ~en;
            step();
        end
        en = 1'b1;
        wait_idle(400);
        run(2);
        wait_idle(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
